rv_dmem_responder: RTL and testbench

Data-memory responder for the uRV core: the target end of the CPU data-memory interface. Accepts one load or store request at a time, applies a configurable number of wait states, and drives a single-port synchronous SRAM (1-cycle read latency). It then returns `dm_ready`, `dm_load_done`, `dm_store_done` and the load word to the core. It sits between the CPU top and the on-chip data RAM.

---
 rtl/rv_dmem_pkg.sv | 15 +
 rtl/rv_dmem_responder.sv | 138 +++++++++++++
 tb/tb_rv_dmem_responder.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_dmem_pkg.sv
// Shared definitions for the uRV data-memory responder: FSM encodings,
// the word returned for failed loads and the wait-counter width.
package rv_dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } dmem_state_t;

   localparam logic [31:0] DMEM_ERR_DATA = 32'h0;
   localparam int          WAIT_CNT_W    = 3;

endpackage

// File: rtl/rv_dmem_responder.sv
// Target end of the uRV data-memory interface: accepts one load/store at a
// time, inserts WAIT_STATES cycles, then drives a 1-cycle-latency SRAM.
module rv_dmem_responder
   import rv_dmem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [31:0]           dm_addr_i,
   input  logic [31:0]           dm_data_s_i,
   input  logic [3:0]            dm_data_select_i,
   input  logic                  dm_load_i,
   input  logic                  dm_store_i,
   output logic                  dm_ready_o,
   output logic [31:0]           dm_data_l_o,
   output logic                  dm_load_done_o,
   output logic                  dm_store_done_o,
   output logic                  dm_err_o,
   output logic                  ram_en_o,
   output logic [3:0]            ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [31:0]           ram_wdata_o,
   input  logic [31:0]           ram_rdata_i
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

   dmem_state_t             r_state;
   dmem_state_t             w_state_next;
   logic [WAIT_CNT_W-1:0]   r_wcnt;
   logic [WAIT_CNT_W-1:0]   w_wcnt_next;
   logic                    r_ready;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [31:0]             r_wdata;
   logic [3:0]              r_sel;
   logic                    r_is_store;
   logic                    r_both;
   logic                    r_range_err;
   logic [31:0]             r_data_l;
   logic                    r_load_done;
   logic                    r_store_done;
   logic                    r_err;
   logic                    w_accept;
   logic                    w_range_err;
   logic                    w_ram_en;
   logic [3:0]              w_ram_we;
   logic                    w_unused;

   // Byte offset bits are meaningless for a word-wide port.
   assign w_unused    = &{1'b0, dm_addr_i[1:0]};
   assign w_accept    = r_ready & (dm_load_i | dm_store_i);
   assign w_range_err = |dm_addr_i[31:ADDR_WIDTH+2];

   always_comb begin
      w_state_next = r_state;
      w_wcnt_next  = r_wcnt;
      w_ram_en     = 1'b0;
      w_ram_we     = 4'b0000;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_wcnt_next  = WAIT_LOAD;
               w_state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
            end
         end
         ST_WAIT: begin
            if (r_wcnt == '0) begin
               w_state_next = ST_ACCESS;
            end else begin
               w_wcnt_next = r_wcnt - 1'b1;
            end
         end
         ST_ACCESS: begin
            // Out-of-range requests still walk the FSM but never touch the RAM.
            w_ram_en     = ~r_range_err;
            w_ram_we     = (r_is_store && !r_range_err) ? r_sel : 4'b0000;
            w_state_next = ST_RESP;
         end
         ST_RESP: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state      <= ST_IDLE;
         r_wcnt       <= '0;
         r_ready      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_sel        <= '0;
         r_is_store   <= 1'b0;
         r_both       <= 1'b0;
         r_range_err  <= 1'b0;
         r_data_l     <= '0;
         r_load_done  <= 1'b0;
         r_store_done <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_wcnt       <= w_wcnt_next;
         r_ready      <= (w_state_next == ST_IDLE);
         r_load_done  <= (r_state == ST_RESP) && !r_is_store;
         r_store_done <= (r_state == ST_RESP) && r_is_store;
         r_err        <= (r_state == ST_RESP) && (r_range_err || r_both);
         if (w_accept) begin
            r_addr      <= dm_addr_i[ADDR_WIDTH+1:2];
            r_wdata     <= dm_data_s_i;
            r_sel       <= dm_data_select_i;
            r_is_store  <= dm_store_i;
            r_both      <= dm_load_i & dm_store_i;
            r_range_err <= w_range_err;
         end
         // RAM read data is valid in RESP, one cycle after the ACCESS enable.
         if ((r_state == ST_RESP) && !r_is_store) begin
            r_data_l <= r_range_err ? DMEM_ERR_DATA : ram_rdata_i;
         end
      end
   end

   assign dm_ready_o      = r_ready;
   assign dm_data_l_o     = r_data_l;
   assign dm_load_done_o  = r_load_done;
   assign dm_store_done_o = r_store_done;
   assign dm_err_o        = r_err;
   assign ram_en_o        = w_ram_en;
   assign ram_we_o        = w_ram_we;
   assign ram_addr_o      = r_addr;
   assign ram_wdata_o     = r_wdata;

endmodule

// File: tb/tb_rv_dmem_responder.sv
// Directed bench for rv_dmem_responder: three instances (WAIT_STATES 1, 0, 3)
// each backed by a behavioural single-port SRAM with 1-cycle read latency.
module rv_spram_model #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          en,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] mem [2**AW];

   always @(posedge clk) begin
      if (en) begin
         for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
         rdata <= mem[addr];
      end
   end
endmodule

module tb_rv_dmem_responder;

   logic        clk;
   logic        rst_n     [3];
   logic [31:0] addr      [3];
   logic [31:0] wdata     [3];
   logic [3:0]  sel       [3];
   logic        ld        [3];
   logic        st        [3];
   logic        ready     [3];
   logic [31:0] data_l    [3];
   logic        load_done [3];
   logic        store_done[3];
   logic        err       [3];
   logic        ram_en    [3];
   logic [3:0]  ram_we    [3];
   logic [11:0] ram_addr  [3];
   logic [31:0] ram_wdata [3];
   logic [31:0] ram_rdata [3];

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      rv_dmem_responder #(
         .ADDR_WIDTH (12),
         .WAIT_STATES((gi == 0) ? 1 : ((gi == 1) ? 0 : 3))
      ) u_dut (
         .clk_i           (clk),
         .rst_n_i         (rst_n[gi]),
         .dm_addr_i       (addr[gi]),
         .dm_data_s_i     (wdata[gi]),
         .dm_data_select_i(sel[gi]),
         .dm_load_i       (ld[gi]),
         .dm_store_i      (st[gi]),
         .dm_ready_o      (ready[gi]),
         .dm_data_l_o     (data_l[gi]),
         .dm_load_done_o  (load_done[gi]),
         .dm_store_done_o (store_done[gi]),
         .dm_err_o        (err[gi]),
         .ram_en_o        (ram_en[gi]),
         .ram_we_o        (ram_we[gi]),
         .ram_addr_o      (ram_addr[gi]),
         .ram_wdata_o     (ram_wdata[gi]),
         .ram_rdata_i     (ram_rdata[gi])
      );

      rv_spram_model #(.AW(12)) u_ram (
         .clk  (clk),
         .en   (ram_en[gi]),
         .we   (ram_we[gi]),
         .addr (ram_addr[gi]),
         .wdata(ram_wdata[gi]),
         .rdata(ram_rdata[gi])
      );
   end

   // One request, waits for ready first; returns what was seen until the done pulse.
   task automatic do_req(input int d, input logic l, input logic s, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] se,
                         output int lat, output logic gl, output logic gs, output logic ge,
                         output logic sen, output logic swe, output logic [31:0] dl,
                         output logic [11:0] eaddr);
      int guard;
      lat = 0; gl = 0; gs = 0; ge = 0; sen = 0; swe = 0; dl = '0; eaddr = '0;
      guard = 0;
      @(negedge clk);
      while (!ready[d] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!ready[d]) begin
         n_checks++; n_fail++;
         $display("FAIL ready_timeout inst=%0d ready=%0b required=1", d, ready[d]);
         return;
      end
      addr[d] = a; wdata[d] = wd; sel[d] = se; ld[d] = l; st[d] = s;
      @(posedge clk); #1;
      ld[d] = 1'b0; st[d] = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (ram_en[d]) begin sen = 1'b1; eaddr = ram_addr[d]; end
         if (ram_we[d] != 4'b0000) swe = 1'b1;
         if (load_done[d] || store_done[d]) begin
            lat = c; gl = load_done[d]; gs = store_done[d]; ge = err[d]; dl = data_l[d];
            break;
         end
      end
      if (lat == 0) begin
         n_checks++; n_fail++;
         $display("FAIL done_timeout inst=%0d addr=%h no done pulse within 20 cycles", d, a);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         n_checks++;
         if ({ready[d], load_done[d], store_done[d], err[d], ram_en[d]} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl inst=%0d got rdy/ld/st/err/en=%b required 00000", d,
                     {ready[d], load_done[d], store_done[d], err[d], ram_en[d]});
         end
         n_checks++;
         if ({ram_we[d], ram_addr[d], ram_wdata[d], data_l[d]} !== 80'h0) begin
            n_fail++;
            $display("FAIL reset_data inst=%0d we=%h addr=%h wdata=%h data_l=%h required all 0",
                     d, ram_we[d], ram_addr[d], ram_wdata[d], data_l[d]);
         end
      end
      for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         n_checks++;
         if (ready[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready inst=%0d got %b required 1", d, ready[d]);
         end
      end
   endtask

   task automatic test_basic();
      int lat; logic gl, gs, ge, sen, swe; logic [31:0] dl; logic [11:0] ea;
      do_req(0, 0, 1, 32'h100, 32'hCAFEBABE, 4'hF, lat, gl, gs, ge, sen, swe, dl, ea);
      n_checks++;
      if ({lat, gl, gs, ge, swe} !== {32'd4, 1'b0, 1'b1, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL basic_store lat=%0d ld=%b st=%b err=%b we=%b required lat=4 ld=0 st=1 err=0 we=1",
                  lat, gl, gs, ge, swe);
      end
      n_checks++;
      if (ea !== 12'h040) begin
         n_fail++;
         $display("FAIL basic_ram_addr got %h required 040", ea);
      end
      do_req(0, 1, 0, 32'h100, 32'h0, 4'h0, lat, gl, gs, ge, sen, swe, dl, ea);
      n_checks++;
      if ({lat, gl, gs, ge, swe} !== {32'd4, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL basic_load lat=%0d ld=%b st=%b err=%b we=%b required lat=4 ld=1 st=0 err=0 we=0",
                  lat, gl, gs, ge, swe);
      end
      n_checks++;
      if (dl !== 32'hCAFEBABE) begin
         n_fail++;
         $display("FAIL basic_load_data got %h required CAFEBABE", dl);
      end
   endtask

   task automatic test_byte_lanes();
      int lat; logic gl, gs, ge, sen, swe; logic [31:0] dl; logic [11:0] ea;
      do_req(0, 0, 1, 32'h200, 32'h11223344, 4'hF, lat, gl, gs, ge, sen, swe, dl, ea);
      do_req(0, 0, 1, 32'h200, 32'hAABBCCDD, 4'b0101, lat, gl, gs, ge, sen, swe, dl, ea);
      do_req(0, 1, 0, 32'h200, 32'h0, 4'h0, lat, gl, gs, ge, sen, swe, dl, ea);
      n_checks++;
      if (dl !== 32'h11BB33DD || gl !== 1'b1) begin
         n_fail++;
         $display("FAIL byte_lanes got %h ld=%b required 11BB33DD ld=1", dl, gl);
      end
   endtask

   task automatic test_out_of_range();
      int lat; logic gl, gs, ge, sen, swe; logic [31:0] dl; logic [11:0] ea;
      do_req(0, 1, 0, 32'h0000_4000, 32'h0, 4'h0, lat, gl, gs, ge, sen, swe, dl, ea);
      n_checks++;
      if ({lat, gl, ge, sen} !== {32'd4, 1'b1, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL oor_load lat=%0d ld=%b err=%b en=%b required lat=4 ld=1 err=1 en=0",
                  lat, gl, ge, sen);
      end
      n_checks++;
      if (dl !== 32'h0) begin
         n_fail++;
         $display("FAIL oor_load_data got %h required 00000000", dl);
      end
      do_req(0, 0, 1, 32'h0000_4000, 32'hFFFFFFFF, 4'hF, lat, gl, gs, ge, sen, swe, dl, ea);
      n_checks++;
      if ({lat, gs, ge, sen, swe} !== {32'd4, 1'b1, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL oor_store lat=%0d st=%b err=%b en=%b we=%b required lat=4 st=1 err=1 en=0 we=0",
                  lat, gs, ge, sen, swe);
      end
   endtask

   task automatic test_simultaneous();
      int lat; logic gl, gs, ge, sen, swe; logic [31:0] dl; logic [11:0] ea;
      do_req(0, 1, 1, 32'h10, 32'h5A5A1234, 4'hF, lat, gl, gs, ge, sen, swe, dl, ea);
      n_checks++;
      if ({gl, gs, ge, swe} !== 4'b0111) begin
         n_fail++;
         $display("FAIL both_req ld=%b st=%b err=%b we=%b required ld=0 st=1 err=1 we=1",
                  gl, gs, ge, swe);
      end
      n_checks++;
      if (dl !== 32'h0) begin
         n_fail++;
         $display("FAIL store_keeps_load_word got %h required 00000000", dl);
      end
      do_req(0, 0, 1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, gl, gs, ge, sen, swe, dl, ea);
      n_checks++;
      if ({gs, ge, sen, swe} !== 4'b1010) begin
         n_fail++;
         $display("FAIL zero_select st=%b err=%b en=%b we=%b required st=1 err=0 en=1 we=0",
                  gs, ge, sen, swe);
      end
      do_req(0, 1, 0, 32'h10, 32'h0, 4'h0, lat, gl, gs, ge, sen, swe, dl, ea);
      n_checks++;
      if (dl !== 32'h5A5A1234 || ge !== 1'b0) begin
         n_fail++;
         $display("FAIL both_reread got %h err=%b required 5A5A1234 err=0", dl, ge);
      end
   endtask

   task automatic test_back_to_back();
      int lat; logic gl, gs, ge, sen, swe; logic [31:0] dl; logic [11:0] ea;
      logic [31:0] a_tab [3];
      logic [31:0] v_tab [3];
      int done_cyc [3];
      logic [31:0] done_dat [3];
      int nd, k, guard;
      logic prev_acc, extra_st;
      a_tab[0] = 32'h20; a_tab[1] = 32'h24; a_tab[2] = 32'h28;
      v_tab[0] = 32'hA0000001; v_tab[1] = 32'hB0000002; v_tab[2] = 32'hC0000003;
      for (int i = 0; i < 3; i++) begin
         do_req(1, 0, 1, a_tab[i], v_tab[i], 4'hF, lat, gl, gs, ge, sen, swe, dl, ea);
         n_checks++;
         if (lat !== 3 || gs !== 1'b1) begin
            n_fail++;
            $display("FAIL ws0_store_latency idx=%0d lat=%0d st=%b required lat=3 st=1", i, lat, gs);
         end
      end
      nd = 0; k = 0; guard = 0; extra_st = 1'b0;
      for (int i = 0; i < 3; i++) begin done_cyc[i] = 0; done_dat[i] = '0; end
      @(negedge clk);
      while (!ready[1] && guard < 20) begin @(negedge clk); guard++; end
      addr[1] = a_tab[0]; ld[1] = 1'b1;
      prev_acc = ready[1];
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (store_done[1]) extra_st = 1'b1;
         if (load_done[1]) begin
            if (nd < 3) begin done_cyc[nd] = c; done_dat[nd] = data_l[1]; end
            nd++;
         end
         if (prev_acc) begin
            k++;
            if (k < 3) addr[1] = a_tab[k];
            else ld[1] = 1'b0;
         end
         prev_acc = ready[1] & ld[1];
      end
      ld[1] = 1'b0;
      n_checks++;
      if (nd !== 3 || k !== 3 || extra_st !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_count dones=%0d accepts=%0d store_done=%b required 3 3 0", nd, k, extra_st);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (done_cyc[i] !== 3 * (i + 1) || done_dat[i] !== v_tab[i]) begin
            n_fail++;
            $display("FAIL b2b_done idx=%0d cycle=%0d data=%h required cycle=%0d data=%h",
                     i, done_cyc[i], done_dat[i], 3 * (i + 1), v_tab[i]);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      int lat; logic gl, gs, ge, sen, swe; logic [31:0] dl; logic [11:0] ea;
      logic saw_we, saw_done;
      int guard;
      do_req(2, 0, 1, 32'h40, 32'h12345678, 4'hF, lat, gl, gs, ge, sen, swe, dl, ea);
      n_checks++;
      if (lat !== 6 || gs !== 1'b1) begin
         n_fail++;
         $display("FAIL ws3_store_latency lat=%0d st=%b required lat=6 st=1", lat, gs);
      end
      saw_we = 1'b0; saw_done = 1'b0; guard = 0;
      @(negedge clk);
      while (!ready[2] && guard < 20) begin @(negedge clk); guard++; end
      addr[2] = 32'h40; wdata[2] = 32'hDEADBEEF; sel[2] = 4'hF; st[2] = 1'b1;
      @(posedge clk); #1;
      st[2] = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (ram_we[2] != 4'b0000) saw_we = 1'b1;
      end
      rst_n[2] = 1'b0;
      #1;
      n_checks++;
      if (ready[2] !== 1'b0 || ram_en[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async_clear ready=%b en=%b required 0 0", ready[2], ram_en[2]);
      end
      repeat (2) @(negedge clk);
      rst_n[2] = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (ram_we[2] != 4'b0000) saw_we = 1'b1;
         if (load_done[2] || store_done[2] || err[2]) saw_done = 1'b1;
         if (c == 1) begin
            n_checks++;
            if (ready[2] !== 1'b1) begin
               n_fail++;
               $display("FAIL reset_mid_ready got %b required 1", ready[2]);
            end
         end
      end
      n_checks++;
      if (saw_we !== 1'b0 || saw_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_side_effects we=%b done=%b required 0 0", saw_we, saw_done);
      end
      do_req(2, 1, 0, 32'h40, 32'h0, 4'h0, lat, gl, gs, ge, sen, swe, dl, ea);
      n_checks++;
      if (dl !== 32'h12345678 || lat !== 6) begin
         n_fail++;
         $display("FAIL reset_mid_reread data=%h lat=%0d required 12345678 lat=6", dl, lat);
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst_n[d] = 1'b0; addr[d] = '0; wdata[d] = '0; sel[d] = '0; ld[d] = 1'b0; st[d] = 1'b0;
      end
      test_reset();
      test_basic();
      test_byte_lanes();
      test_out_of_range();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
